fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width of program memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_ADDR, default 0, first fetch address after reset.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 mem_req_o  output  1  fetch request to program memory.
REQ-008 mem_addr_o  output  ADDR_WIDTH  word address of the current request.
REQ-009 mem_ack_i  input  1  memory completes the request this cycle.
REQ-010 mem_data_i  input  DATA_WIDTH  instruction word, valid when mem_ack_i=1.
REQ-011 instr_valid_o  output  1  queue head holds a valid instruction.
REQ-012 instr_o  output  DATA_WIDTH  head instruction.
REQ-013 instr_addr_o  output  ADDR_WIDTH  word address of head instruction.
REQ-014 instr_ready_i  input  1  core consumes the head this cycle.
REQ-015 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-016 redirect_addr_i  input  ADDR_WIDTH  new fetch address.

Function
REQ-017 Queue SHALL be a DEPTH-entry FIFO storing {address, instruction}; outputs driven from head entry, registered storage, no combinational path from mem_data_i to instr_o.
REQ-018 Pop SHALL occur on a cycle with instr_valid_o=1 and instr_ready_i=1; instr_ready_i ignored when queue empty.
REQ-019 FSM states: IDLE (no outstanding request), REQ (request outstanding, response kept), DROP (request outstanding, response discarded).
REQ-020 IDLE->REQ when count+0 < DEPTH and no redirect; mem_req_o asserts that same cycle with mem_addr_o = fetch_pc.
REQ-021 In REQ/DROP mem_req_o SHALL stay 1 and mem_addr_o stable until the cycle mem_ack_i=1.
REQ-022 On ack in REQ: push {mem_addr_o, mem_data_i}, fetch_pc increments by 1 modulo 2^ADDR_WIDTH; if count after push/pop < DEPTH, remain in REQ with new address next cycle (back-to-back, one request per cycle max), else IDLE.
REQ-023 New request SHALL only be issued when an entry is guaranteed free (count, including same-cycle push minus pop, < DEPTH); queue SHALL never overflow.
REQ-024 Simultaneous push and pop SHALL keep count unchanged; pop of an empty queue and push beyond DEPTH SHALL be impossible by construction.
REQ-025 redirect_i=1 SHALL, next cycle: empty queue (instr_valid_o=0), set fetch_pc=redirect_addr_i; redirect overrides any same-cycle pop or push.
REQ-026 Redirect in IDLE, or in REQ/DROP coincident with mem_ack_i=1: next state REQ at redirect_addr_i (ack data discarded).
REQ-027 Redirect in REQ/DROP without ack: next state DROP; outstanding address held; on its ack, data discarded, next state REQ at redirect address.
REQ-028 Repeated redirects while in DROP SHALL update fetch_pc to the latest redirect_addr_i.
REQ-029 mem_ack_i while mem_req_o=0 SHALL be ignored.
REQ-030 Address wrap: 2^ADDR_WIDTH-1 increments to 0.
REQ-031 Latency: with zero-wait memory (ack same cycle as req), first instruction valid 1 cycle after first ack edge; sustained throughput 1 instruction/cycle.

Reset
REQ-032 While rst=1 (asynchronously): state IDLE, queue empty, fetch_pc=RESET_ADDR, mem_req_o=0, instr_valid_o=0, instr_o=0, instr_addr_o=0, mem_addr_o=RESET_ADDR.
REQ-033 Reset mid-request SHALL abandon the outstanding request; first cycle after release mem_req_o=1, mem_addr_o=RESET_ADDR.

Verification
REQ-034 Zero-wait memory, instr_ready_i=1 constant -> instr_addr_o 0,1,2,3... on consecutive cycles, instr_o matching memory words, no bubbles after the first.
REQ-035 instr_ready_i=0, memory acks immediately -> exactly 4 requests (addr 0..3), mem_req_o=0 afterwards, count=4; one pop -> one request at addr 4.
REQ-036 Memory with 3-cycle ack delay, redirect_i=1 to addr 0x100 one cycle after request to 0x002 -> mem_addr_o holds 0x002 until ack, data discarded, next request 0x100, first valid instr_addr_o=0x100.
REQ-037 redirect_i to 0x3FF coincident with ack and pop -> queue empty next cycle, fetch 0x3FF then 0x000 (wrap).
REQ-038 rst asserted while in REQ with 2 queued entries -> instr_valid_o=0 and mem_req_o=0 immediately; after release first request at RESET_ADDR.
REQ-039 Random ack delays/ready/redirects with scoreboard -> delivered sequence equals program order from each redirect target, no loss, no duplicates, count never >DEPTH.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: program-memory request/response channel and the
// instruction delivery/redirect channel toward the core.
interface fetch_queue_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_data_i;
  logic                  instr_valid_o;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0] instr_addr_o;
  logic                  instr_ready_i;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_addr_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_ack_i, mem_data_i,
    output instr_valid_o, instr_o, instr_addr_o,
    input  instr_ready_i, redirect_i, redirect_addr_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_ack_i, mem_data_i,
    input  instr_valid_o, instr_o, instr_addr_o,
    output instr_ready_i, redirect_i, redirect_addr_i
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues one outstanding program-memory request at a
// time, buffers {address, instruction} pairs and flushes/refetches on redirect.
module fetch_queue #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]         FULL   = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t                r_state;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [ADDR_WIDTH-1:0] r_q_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_q_data [DEPTH];

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_ack;
  logic                  w_push;
  logic [CW-1:0]         w_count_nxt;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  // Redirect wins over any same-cycle push or pop; acks without a request are ignored.
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid & bus.instr_ready_i & ~bus.redirect_i;
  assign w_ack       = r_mem_req & bus.mem_ack_i;
  assign w_push      = w_ack & (r_state == S_REQ) & ~bus.redirect_i;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_next_addr = r_mem_addr + ADDR_WIDTH'(1);

  assign bus.mem_req_o     = r_mem_req;
  assign bus.mem_addr_o    = r_mem_addr;
  assign bus.instr_valid_o = w_valid;
  assign bus.instr_o       = w_valid ? r_q_data[r_head] : '0;
  assign bus.instr_addr_o  = w_valid ? r_q_addr[r_head] : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_tail] <= r_mem_addr;
      r_q_data[r_tail] <= bus.mem_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.redirect_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RST_PC;
      r_fetch_pc <= RST_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.redirect_i) begin
            r_state    <= S_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= bus.redirect_addr_i;
            r_fetch_pc <= bus.redirect_addr_i;
          end else if (r_count < FULL) begin
            r_state    <= S_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        S_REQ, S_DROP: begin
          if (bus.redirect_i) begin
            r_fetch_pc <= bus.redirect_addr_i;
            if (w_ack) begin
              r_state    <= S_REQ;
              r_mem_addr <= bus.redirect_addr_i;
            end else begin
              r_state <= S_DROP;
            end
          end else if (w_ack) begin
            if (r_state == S_DROP) begin
              r_state    <= S_REQ;
              r_mem_addr <= r_fetch_pc;
            end else begin
              r_fetch_pc <= w_next_addr;
              // Back-to-back only while a slot is guaranteed for the next response.
              if (w_count_nxt < FULL) begin
                r_mem_addr <= w_next_addr;
              end else begin
                r_state   <= S_IDLE;
                r_mem_req <= 1'b0;
              end
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based reference model.
module tb_fetch_queue;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RA = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_ADDR(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a, {(DW-AW){1'b0}}} ^ 32'h1357_9BDF ^ {{(DW-AW){1'b0}}, a};
  endfunction

  // Reference model: a queue of delivered words plus the one outstanding fetch.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc    = RA;
  logic [AW-1:0] m_oaddr = RA;
  bit            m_out   = 1'b0;
  bit            m_disc  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_pc    = RA;
      m_oaddr = RA;
      m_out   = 1'b0;
      m_disc  = 1'b0;
    end else begin : model_step
      int cnt0;
      bit pop;
      bit got;
      cnt0 = mq.size();
      pop  = (cnt0 != 0) && (bus.instr_ready_i === 1'b1);
      got  = m_out && (bus.mem_ack_i === 1'b1);
      if (bus.redirect_i === 1'b1) begin
        mq.delete();
        m_pc = bus.redirect_addr_i;
        if (!m_out || got) begin
          m_out   = 1'b1;
          m_oaddr = bus.redirect_addr_i;
          m_disc  = 1'b0;
        end else begin
          m_disc = 1'b1;
        end
      end else begin
        if (pop) void'(mq.pop_front());
        if (got) begin
          if (m_disc) begin
            m_disc  = 1'b0;
            m_oaddr = m_pc;
          end else begin
            mq.push_back('{a: m_oaddr, d: mem_fn(m_oaddr)});
            m_pc = m_oaddr + AW'(1);
            if (mq.size() < DEPTH) m_oaddr = m_pc;
            else m_out = 1'b0;
          end
        end else if (!m_out && cnt0 < DEPTH) begin
          m_out   = 1'b1;
          m_oaddr = m_pc;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("mem_req", bus.mem_req_o, m_out);
    if (rst) chk("mem_addr_rst", bus.mem_addr_o, RA);
    else if (m_out) chk("mem_addr", bus.mem_addr_o, m_oaddr);
    chk("instr_valid", bus.instr_valid_o, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("instr_addr", bus.instr_addr_o, mq[0].a);
      chk("instr", bus.instr_o, mq[0].d);
    end else if (rst) begin
      chk("instr_addr_rst", bus.instr_addr_o, 0);
      chk("instr_rst", bus.instr_o, 0);
    end
  end

  // Memory responder.
  int            wait_left   = -1;
  int            max_delay   = 0;
  bit            fixed_delay = 1'b1;
  bit            spur_en     = 1'b0;
  int            ack_cnt     = 0;
  logic [AW-1:0] last_ack    = '0;

  always @(posedge clk) begin
    #1;
    if (rst || bus.mem_req_o !== 1'b1) begin
      wait_left     = -1;
      bus.mem_ack_i = spur_en && !rst && ($urandom_range(0, 7) == 0);
      bus.mem_data_i = $urandom;
    end else begin
      if (wait_left < 0)
        wait_left = fixed_delay ? max_delay : int'($urandom_range(0, max_delay));
      if (wait_left == 0) begin
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = mem_fn(bus.mem_addr_o);
        wait_left      = -1;
        ack_cnt++;
        last_ack = bus.mem_addr_o;
      end else begin
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = $urandom;
        wait_left--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_ready_i   = 1'b0;
    bus.redirect_i      = 1'b0;
    bus.redirect_addr_i = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    bus.instr_ready_i   = 1'b0;
    bus.redirect_i      = 1'b0;
    bus.redirect_addr_i = '0;

    // Reset state
    tick();
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, RA);
    chk("rst_valid", bus.instr_valid_o, 0);
    chk("rst_instr", bus.instr_o, 0);
    chk("rst_instr_addr", bus.instr_addr_o, 0);

    // Zero-wait streaming, always ready
    max_delay = 0; fixed_delay = 1'b1; spur_en = 1'b0;
    do_reset();
    bus.instr_ready_i = 1'b1;
    tick();
    chk("A_first_req", bus.mem_req_o, 1);
    chk("A_first_addr", bus.mem_addr_o, 0);
    tick();
    chk("A_first_valid", bus.instr_valid_o, 1);
    chk("A_first_iaddr", bus.instr_addr_o, 0);
    chk("A_first_instr", bus.instr_o, 32'h1357_9BDF);
    for (int k = 1; k < 7; k++) begin
      tick();
      chk("A_stream_valid", bus.instr_valid_o, 1);
      chk("A_stream_iaddr", bus.instr_addr_o, k);
    end

    // Core stalled: queue fills with exactly DEPTH fetches, one pop frees one slot
    do_reset();
    base = ack_cnt;
    for (int k = 0; k < 12; k++) tick();
    chk("B_acks", ack_cnt - base, 4);
    chk("B_req_idle", bus.mem_req_o, 0);
    chk("B_head", bus.instr_addr_o, 0);
    bus.instr_ready_i = 1'b1;
    tick();
    bus.instr_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("B_acks_after_pop", ack_cnt - base, 5);
    chk("B_last_addr", last_ack, 4);
    chk("B_req_idle2", bus.mem_req_o, 0);
    chk("B_head2", bus.instr_addr_o, 1);

    // Redirect while a slow request is outstanding
    max_delay = 3;
    do_reset();
    bus.instr_ready_i = 1'b1;
    n = 0;
    while (!(bus.mem_req_o === 1'b1 && bus.mem_addr_o == 10'h002) && n < 40) begin tick(); n++; end
    chk("C_wait_req2", n < 40, 1);
    tick();
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 10'h100;
    tick();
    bus.redirect_i = 1'b0;
    chk("C_hold_req", bus.mem_req_o, 1);
    chk("C_hold_addr", bus.mem_addr_o, 10'h002);
    chk("C_flushed", bus.instr_valid_o, 0);
    n = 0;
    while (bus.mem_addr_o == 10'h002 && n < 20) begin tick(); n++; end
    chk("C_next_addr", bus.mem_addr_o, 10'h100);
    n = 0;
    while (bus.instr_valid_o !== 1'b1 && n < 20) begin tick(); n++; end
    chk("C_first_iaddr", bus.instr_addr_o, 10'h100);

    // Redirect coincident with ack and pop, wrapping address
    max_delay = 0;
    do_reset();
    bus.instr_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("D_pre_valid", bus.instr_valid_o, 1);
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 10'h3FF;
    tick();
    bus.redirect_i = 1'b0;
    chk("D_empty", bus.instr_valid_o, 0);
    chk("D_req_3ff", bus.mem_addr_o, 10'h3FF);
    tick();
    chk("D_iaddr_3ff", bus.instr_addr_o, 10'h3FF);
    chk("D_wrap_req", bus.mem_addr_o, 10'h000);
    tick();
    chk("D_iaddr_wrap", bus.instr_addr_o, 10'h000);

    // Asynchronous reset mid-request with two queued entries
    max_delay = 2;
    do_reset();
    n = 0;
    while (!(mq.size() == 2 && bus.mem_req_o === 1'b1) && n < 40) begin tick(); n++; end
    chk("E_wait_two", n < 40, 1);
    chk("E_two_valid", bus.instr_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("E_async_req", bus.mem_req_o, 0);
    chk("E_async_valid", bus.instr_valid_o, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("E_restart_req", bus.mem_req_o, 1);
    chk("E_restart_addr", bus.mem_addr_o, RA);

    // Randomized traffic: delays, stalls, redirects, spurious acks
    max_delay = 3; fixed_delay = 1'b0; spur_en = 1'b1;
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      tick();
      if (k < 2500) bus.instr_ready_i = ($urandom_range(0, 3) != 0);
      else          bus.instr_ready_i = ($urandom_range(0, 3) == 0);
      bus.redirect_i = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) bus.redirect_addr_i = AW'($urandom);
      else bus.redirect_addr_i = 10'h3FC + AW'($urandom_range(0, 3));
    end
    bus.redirect_i    = 1'b0;
    bus.instr_ready_i = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
